// File: rtl/signext_inv.sv
// 16-to-8 signed saturating narrowing stage with skid-buffered output
// and sticky/counted saturation statistics.
module signext_inv #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_sat,
  input  logic                 clr_stats,
  output logic                 sat_sticky,
  output logic [CNT_WIDTH-1:0] sat_count
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t     state;
  logic [7:0] skid_data;
  logic       skid_sat;

  logic       fits;
  logic [7:0] nar_data;
  logic       nar_sat;
  logic       accept;
  logic       deliver;

  // Value fits in 8 bits iff bits 15..7 are a pure sign run
  assign fits     = (in_data[15:7] == '0) || (in_data[15:7] == '1);
  assign nar_sat  = !fits;
  assign nar_data = fits        ? in_data[7:0] :
                    in_data[15] ? 8'h80 : 8'h7F;

  assign in_ready  = rst_n && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_data  <= 8'h00;
      out_sat   <= 1'b0;
      skid_data <= 8'h00;
      skid_sat  <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            out_data <= nar_data;
            out_sat  <= nar_sat;
            state    <= ONE;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            out_data <= nar_data;
            out_sat  <= nar_sat;
          end else if (accept) begin
            skid_data <= nar_data;
            skid_sat  <= nar_sat;
            state     <= FULL;
          end else if (deliver) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            out_data <= skid_data;
            out_sat  <= skid_sat;
            state    <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Stats track acceptance; a clear in the same cycle wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (clr_stats) begin
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (accept && nar_sat) begin
      sat_sticky <= 1'b1;
      if (sat_count != '1)
        sat_count <= sat_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_signext_inv.sv
// Bench for signext_inv: queue-based reference model checked every
// cycle, plus directed literal expectations on two counter widths.
module tb_signext_inv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        clr_stats;

  logic        ir_a, ov_a, os_a, st_a;
  logic [7:0]  od_a;
  logic [15:0] cnt_a;
  logic        ir_b, ov_b, os_b, st_b;
  logic [7:0]  od_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signext_inv #(.CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .out_sat(os_a),
    .clr_stats(clr_stats), .sat_sticky(st_a), .sat_count(cnt_a)
  );

  signext_inv #(.CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
    .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .out_sat(os_b),
    .clr_stats(clr_stats), .sat_sticky(st_b), .sat_count(cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference narrowing by signed range, returns {data, sat}
  function automatic logic [8:0] narrow(input logic [15:0] d);
    int v;
    logic [15:0] t;
    v = int'($signed(d));
    if (v > 127) return {8'h7F, 1'b1};
    if (v < -128) return {8'h80, 1'b1};
    t = d;
    return {t[7:0], 1'b0};
  endfunction

  logic [8:0]  q[$];
  int          cnt = 0;
  bit          sticky = 0;
  bit          was_rst = 1;
  bit          cap_ok = 0;
  bit          started = 0;
  bit          acc_s, del_s, rst_s, clr_s;
  logic [15:0] din_s;

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready_a", 32'(ir_a), 32'(rst_n && q.size() < 2));
      chk("in_ready_b", 32'(ir_b), 32'(rst_n && q.size() < 2));
      chk("out_valid_a", 32'(ov_a), 32'(q.size() != 0));
      chk("out_valid_b", 32'(ov_b), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("word_a", 32'({od_a, os_a}), 32'(q[0]));
        chk("word_b", 32'({od_b, os_b}), 32'(q[0]));
      end else if (was_rst) begin
        chk("rst_word", 32'({od_a, os_a}), 32'(0));
      end
      chk("sticky_a", 32'(st_a), 32'(sticky));
      chk("sticky_b", 32'(st_b), 32'(sticky));
      chk("count_a", 32'(cnt_a), 32'(cnt > 65535 ? 65535 : cnt));
      chk("count_b", 32'(cnt_b), 32'(cnt > 3 ? 3 : cnt));
    end
    rst_s  = rst_n;
    clr_s  = clr_stats;
    din_s  = in_data;
    acc_s  = in_valid && rst_n && (q.size() < 2);
    del_s  = (q.size() != 0) && out_ready;
    cap_ok = 1;
  end

  always @(posedge clk) begin
    logic [8:0] w;
    if (cap_ok) begin
      started = 1;
      w = narrow(din_s);
      if (!rst_s) begin
        q.delete();
        cnt     = 0;
        sticky  = 0;
        was_rst = 1;
      end else begin
        was_rst = 0;
        if (del_s) void'(q.pop_front());
        if (acc_s) q.push_back(w);
        if (clr_s) begin
          cnt    = 0;
          sticky = 0;
        end else if (acc_s && w[0]) begin
          cnt++;
          sticky = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] fit_in[8] = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F,
                             16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
  logic [8:0]  fit_out[8] = '{9'h0FE, 9'h0FF, 9'h100, 9'h101,
                              9'h101, 9'h0FF, 9'h000, 9'h1FE};
  logic [1:0]  sat_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    repeat (3) step();
    chk("reset_valid", 32'(ov_a), 32'(0));
    chk("reset_data", 32'({od_a, os_a}), 32'(0));
    chk("reset_count", 32'(cnt_a), 32'(0));
    chk("reset_ready", 32'(ir_a), 32'(0));
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(ir_a), 32'(1));

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = fit_in[i];
      step();
      chk("fit_word", 32'({ov_a, od_a, os_a}), 32'({1'b1, fit_out[i]}));
    end
    in_valid = 1'b0;
    step();
    chk("fit_count", 32'(cnt_a), 32'(4));
    chk("fit_count_b", 32'(cnt_b), 32'(3));
    chk("fit_sticky", 32'(st_a), 32'(1));

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0001;
    step();
    in_data = 16'h0002;
    step();
    chk("bp_full_ready", 32'(ir_a), 32'(0));
    in_data = 16'h0003;
    step();
    chk("bp_hold_ready", 32'(ir_a), 32'(0));
    chk("bp_hold_word", 32'({od_a, os_a}), 32'({8'h01, 1'b0}));
    out_ready = 1'b1;
    step();
    chk("bp_second", 32'({od_a, os_a}), 32'({8'h02, 1'b0}));
    chk("bp_ready_back", 32'(ir_a), 32'(1));
    step();
    chk("bp_third", 32'({od_a, os_a}), 32'({8'h03, 1'b0}));
    in_valid = 1'b0;
    step();
    chk("bp_drained", 32'(ov_a), 32'(0));

    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      if ($urandom_range(1) == 1) in_data = 16'($urandom);
      else in_data = {{8{1'b0}}, 8'($urandom)} ^ {16{$urandom_range(1) == 1}};
      step();
      chk("tput_valid", 32'(ov_a), 32'(1));
    end
    in_valid = 1'b0;
    step();

    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      clr_stats = ($urandom_range(15) == 0);
      in_data   = 16'($urandom);
      if ($urandom_range(2) == 0) in_data[15:7] = {9{in_data[6]}};
      step();
    end
    in_valid  = 1'b0;
    clr_stats = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr_count", 32'(cnt_a), 32'(0));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h4000;
      step();
      chk("sat_count_b", 32'(cnt_b), 32'(sat_exp[i]));
      chk("sat_count_a", 32'(cnt_a), 32'(i + 1));
    end
    in_valid = 1'b0;
    chk("sat_sticky_b", 32'(st_b), 32'(1));
    step();

    in_valid  = 1'b1;
    in_data   = 16'h1234;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    in_valid  = 1'b0;
    chk("clr_prec_count", 32'(cnt_a), 32'(0));
    chk("clr_prec_sticky", 32'(st_a), 32'(0));
    chk("clr_prec_word", 32'({ov_a, od_a, os_a}), 32'({1'b1, 8'h7F, 1'b1}));
    step();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h8001;
    step();
    in_data = 16'h0005;
    step();
    chk("mid_full", 32'(ir_a), 32'(0));
    rst_n = 1'b0;
    step();
    chk("mid_valid", 32'(ov_a), 32'(0));
    chk("mid_data", 32'(od_a), 32'(0));
    chk("mid_stats", 32'({st_a, cnt_a}), 32'(0));
    chk("mid_ready_rst", 32'(ir_a), 32'(0));
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_ready", 32'(ir_a), 32'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_stale", 32'(ov_a), 32'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
